// File: rtl/pwm_cmd_sequencer.sv
// SPI command decoder for four PWM channels: parses header/data byte frames,
// holds duty writes in shadow registers and commits them at period boundaries.
module pwm_cmd_sequencer #(
    parameter int width     = 8,
    parameter int TimerBits = 8,
    parameter int MAX_DUTY  = 100,
    parameter int TIMEOUT   = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_valid,
    input  logic [width-1:0]       i_rx_data,
    input  logic                   i_ss_n,
    input  logic [3:0]             i_period_end,
    output logic [4*TimerBits-1:0] o_duty,
    output logic [3:0]             o_load,
    output logic [3:0]             o_ch_en,
    output logic [width-1:0]       o_tx_data,
    output logic                   o_tx_load,
    output logic [1:0]             o_err
);

    localparam int CntBits = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_DATA = 1'b1;

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_EN = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    logic [0:0]                 state;
    logic [CntBits-1:0]         tmo_cnt;
    logic [1:0]                 wr_ch;
    logic [3:0][TimerBits-1:0]  shadow;
    logic [3:0][TimerBits-1:0]  duty_q;
    logic [3:0]                 pending;

    logic                 rx_ok;
    logic                 hdr_rx;
    logic                 data_wr;
    logic                 timeout_hit;
    logic                 clamp_hit;
    logic                 status_b;
    logic [1:0]           hdr_op;
    logic [TimerBits-1:0] duty_new;
    logic [3:0]           commit;

    always_comb begin
        rx_ok       = i_rx_valid & ~i_ss_n;
        hdr_op      = i_rx_data[7:6];
        hdr_rx      = rx_ok & (state == IDLE);
        data_wr     = rx_ok & (state == WAIT_DATA);
        timeout_hit = ~i_ss_n & ~i_rx_valid & (state == WAIT_DATA)
                      & (tmo_cnt == CntBits'(TIMEOUT - 1));
        clamp_hit   = data_wr & (i_rx_data > width'(MAX_DUTY));
        duty_new    = clamp_hit ? TimerBits'(MAX_DUTY) : TimerBits'(i_rx_data);
        status_b    = hdr_rx & (hdr_op == OP_READ) & i_rx_data[0];
        // Uses the registered enable mask, so a same-cycle SET_EN sees the old one
        commit      = pending & (i_period_end | ~o_ch_en);
    end

    assign o_duty = duty_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            wr_ch     <= '0;
            o_ch_en   <= '0;
            o_tx_data <= '0;
            o_tx_load <= 1'b0;
            o_err     <= '0;
        end else begin
            o_tx_load <= 1'b0;
            // A status-B read clears the sticky bits, but a same-cycle event wins
            o_err <= (status_b ? 2'b00 : o_err) | {timeout_hit, clamp_hit};
            if (i_ss_n) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_rx_valid) begin
                            case (hdr_op)
                                OP_WRITE: begin
                                    state   <= WAIT_DATA;
                                    wr_ch   <= i_rx_data[1:0];
                                    tmo_cnt <= '0;
                                end
                                OP_SET_EN: o_ch_en <= i_rx_data[5:2];
                                OP_READ: begin
                                    o_tx_load <= 1'b1;
                                    o_tx_data <= i_rx_data[0] ? width'(o_err)
                                                              : width'({pending, o_ch_en});
                                end
                                default: ;
                            endcase
                        end
                    end
                    WAIT_DATA: begin
                        if (i_rx_valid || tmo_cnt == CntBits'(TIMEOUT - 1))
                            state <= IDLE;
                        else
                            tmo_cnt <= tmo_cnt + CntBits'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A data byte landing on a commit cycle re-arms pending after the old shadow is taken
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            duty_q  <= '0;
            shadow  <= '0;
            pending <= '0;
            o_load  <= '0;
        end else begin
            o_load <= commit;
            for (int unsigned c = 0; c < 4; c++) begin
                if (commit[c]) begin
                    duty_q[c]  <= shadow[c];
                    pending[c] <= 1'b0;
                end
                if (data_wr && wr_ch == 2'(c)) begin
                    shadow[c]  <= duty_new;
                    pending[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Scoreboard bench for pwm_cmd_sequencer: expected o_load/o_tx_load events are
// queued by the stimulus and popped by a negedge monitor.
module tb_pwm_cmd_sequencer;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        ss_n;
    logic [3:0]  period_end;
    logic [31:0] duty;
    logic [3:0]  load;
    logic [3:0]  ch_en;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [1:0]  err;

    typedef struct {
        bit         is_tx;
        int         ch;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pwm_cmd_sequencer #(
        .width    (8),
        .TimerBits(8),
        .MAX_DUTY (100),
        .TIMEOUT  (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .i_ss_n      (ss_n),
        .i_period_end(period_end),
        .o_duty      (duty),
        .o_load      (load),
        .o_ch_en     (ch_en),
        .o_tx_data   (tx_data),
        .o_tx_load   (tx_load),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_load(input int ch, input logic [7:0] val);
        exp_t e;
        e.is_tx = 1'b0; e.ch = ch; e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_tx(input logic [7:0] val);
        exp_t e;
        e.is_tx = 1'b1; e.ch = 0; e.val = val;
        sb.push_back(e);
    endtask

    task automatic mon_event(input bit is_tx, input int ch, input logic [7:0] val);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got tx=%0d ch=%0d val=0x%0h expected none",
                     is_tx, ch, val);
        end else begin
            e = sb.pop_front();
            if (e.is_tx != is_tx || e.ch != ch || e.val !== val) begin
                n_fail++;
                $display("FAIL sb_event: got tx=%0d ch=%0d val=0x%0h expected tx=%0d ch=%0d val=0x%0h",
                         is_tx, ch, val, e.is_tx, e.ch, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_load) mon_event(1'b1, 0, tx_data);
            for (int c = 0; c < 4; c++)
                if (load[c]) mon_event(1'b0, c, duty[c*8 +: 8]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] pe);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b; period_end = pe;
        @(posedge clk); #1;
        rx_valid = 1'b0; period_end = 4'b0000;
    endtask

    task automatic pulse_pe(input logic [3:0] pe);
        @(posedge clk); #1;
        period_end = pe;
        @(posedge clk); #1;
        period_end = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ss_n = 1'b0; period_end = 4'b0000;
        tick(3);
        chk("rst_duty", duty, 32'h0);
        chk("rst_load", {28'h0, load}, 32'h0);
        chk("rst_en", {28'h0, ch_en}, 32'h0);
        chk("rst_tx", {23'h0, tx_load, tx_data}, 32'h0);
        chk("rst_err", {30'h0, err}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Disabled channel commits one cycle after its data byte
        push_load(0, 8'd50);
        send_byte(8'h40, 4'b0000);
        send_byte(8'h32, 4'b0000);
        tick(2);
        chk("t1_duty_ch1", {24'h0, duty[7:0]}, 32'd50);

        // Enabled channel waits for its period boundary
        send_byte(8'hBC, 4'b0000);
        tick(1);
        chk("t2_en", {28'h0, ch_en}, 32'hF);
        send_byte(8'h41, 4'b0000);
        send_byte(8'h40, 4'b0000);
        tick(3);
        chk("t2_ch2_hold", {24'h0, duty[15:8]}, 32'd0);
        push_load(1, 8'd64);
        pulse_pe(4'b0010);
        tick(1);
        chk("t2_ch2_commit", {24'h0, duty[15:8]}, 32'd64);
        send_byte(8'h41, 4'b0010);
        send_byte(8'h20, 4'b0000);
        tick(3);
        chk("t2_no_early", {24'h0, duty[15:8]}, 32'd64);
        push_load(1, 8'd32);
        pulse_pe(4'b0010);
        tick(1);
        chk("t2_ch2_second", {24'h0, duty[15:8]}, 32'd32);

        // Clamp, status-B read clears it
        send_byte(8'h42, 4'b0000);
        send_byte(8'hC8, 4'b0000);
        tick(1);
        chk("t3_err_clamp", {30'h0, err}, 32'h1);
        push_tx(8'h01);
        send_byte(8'hC1, 4'b0000);
        tick(1);
        chk("t3_err_cleared", {30'h0, err}, 32'h0);
        push_load(2, 8'd100);
        pulse_pe(4'b0100);
        tick(1);
        chk("t3_ch3_clamped", {24'h0, duty[23:16]}, 32'd100);

        // Timeout
        send_byte(8'h43, 4'b0000);
        tick(TMO + 5);
        chk("t4_err_tmo", {30'h0, err}, 32'h2);
        chk("t4_ch4_hold", {24'h0, duty[31:24]}, 32'd0);
        push_tx(8'h02);
        send_byte(8'hC1, 4'b0000);
        tick(1);
        chk("t4_err_cleared", {30'h0, err}, 32'h0);

        // Slave-select abort: no error, no write, rx ignored while deselected
        send_byte(8'h43, 4'b0000);
        ss_n = 1'b1;
        send_byte(8'hC1, 4'b0000);
        ss_n = 1'b0;
        tick(TMO + 5);
        chk("t4_ss_no_err", {30'h0, err}, 32'h0);
        chk("t4_ss_no_write", {24'h0, duty[31:24]}, 32'd0);

        // Double write before boundary -> single commit of last value
        send_byte(8'h40, 4'b0000);
        send_byte(8'h1E, 4'b0000);
        send_byte(8'h40, 4'b0000);
        send_byte(8'h0A, 4'b0000);
        tick(2);
        chk("t5_hold", {24'h0, duty[7:0]}, 32'd50);
        push_load(0, 8'd10);
        pulse_pe(4'b0001);
        tick(1);
        chk("t5_commit", {24'h0, duty[7:0]}, 32'd10);
        push_tx(8'h0F);
        send_byte(8'hC0, 4'b0000);
        tick(1);

        // Data byte coincides with commit: old shadow commits, new stays pending
        send_byte(8'h43, 4'b0000);
        send_byte(8'h07, 4'b0000);
        send_byte(8'h43, 4'b0000);
        push_load(3, 8'd7);
        push_load(3, 8'd9);
        send_byte(8'h09, 4'b1000);
        tick(1);
        chk("t7_old_shadow", {24'h0, duty[31:24]}, 32'd7);
        pulse_pe(4'b1000);
        tick(1);
        chk("t7_new_shadow", {24'h0, duty[31:24]}, 32'd9);

        // Mid-operation reset with pending write and open frame
        send_byte(8'h42, 4'b0000);
        send_byte(8'h10, 4'b0000);
        send_byte(8'h40, 4'b0000);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_duty", duty, 32'h0);
        chk("t6_load", {28'h0, load}, 32'h0);
        chk("t6_en", {28'h0, ch_en}, 32'h0);
        chk("t6_tx", {23'h0, tx_load, tx_data}, 32'h0);
        chk("t6_err", {30'h0, err}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pulse_pe(4'b0100);
        tick(2);
        chk("t6_no_commit", duty, 32'h0);
        push_tx(8'h00);
        send_byte(8'hC0, 4'b0000);

        tick(5);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_cmd_sequencer.md
Name: pwm_cmd_sequencer

Overview:
Command decoder and update scheduler between the SPI slave receiver and the four PWM channels. Parses received byte frames into duty-cycle writes, channel-enable updates and status reads. Writes are held in per-channel shadow registers and committed only at each channel's period boundary, so no PWM period is ever truncated. Loads a status byte back into the SPI transmitter on request.

Parameters:
width, 8, SPI byte width (rx/tx data)
TimerBits, 8, PWM duty register width
MAX_DUTY, 100, largest legal duty value; larger writes are clamped
TIMEOUT, 1000, i_clk cycles allowed between header and data byte

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-low
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new SPI byte
i_rx_data  in  width  received SPI byte
i_ss_n  in  1  SPI slave select, active-low
i_period_end  in  4  per-channel one-cycle pulse at PWM counter wrap (bit0 = ch1)
o_duty  out  4*TimerBits  committed duty, ch1 in [TimerBits-1:0]
o_load  out  4  one-cycle pulse per channel when its o_duty field changes
o_ch_en  out  4  channel enable mask
o_tx_data  out  width  status byte for the SPI transmitter
o_tx_load  out  1  one-cycle strobe: latch o_tx_data
o_err  out  2  sticky errors {timeout, clamp}

Behaviour:
- Reset (i_rst=0, async): o_duty=0, shadow=0, pending=0, o_load=0, o_ch_en=0, o_tx_data=0, o_tx_load=0, o_err=0, FSM=IDLE, timeout counter=0.
- Header byte fields: [7:6] op, [1:0] ch.
  - op 00 = NOP.
  - op 01 = WRITE_DUTY; the next byte is the duty value.
  - op 10 = SET_EN; o_ch_en <= hdr[5:2] on the next cycle.
  - op 11 = READ_STATUS; hdr[0]=0 selects status A, hdr[0]=1 selects status B.
- FSM states: IDLE, WAIT_DATA.
  - IDLE + rx_valid + op01 -> WAIT_DATA; latch ch; clear timeout counter.
  - IDLE + other ops: execute, stay in IDLE.
  - WAIT_DATA + rx_valid -> IDLE. Duty = min(byte, MAX_DUTY); if clamped, set o_err[0]. shadow[ch] <= duty, pending[ch] <= 1.
  - WAIT_DATA, counter reaches TIMEOUT-1 with no byte -> IDLE; set o_err[1]; no write.
  - WAIT_DATA + i_ss_n=1 -> IDLE immediately; no write, no error.
  - i_ss_n=1 forces IDLE in every state. i_rx_valid is ignored while i_ss_n=1.
- Commit, per channel c:
  - If pending[c] and (i_period_end[c] or o_ch_en[c]=0): on the next edge o_duty[c] <= shadow[c], o_load[c]=1 for one cycle, pending[c] cleared.
  - A disabled channel therefore commits one cycle after its data byte.
- Simultaneous events:
  - New data byte in the same cycle as a commit for that channel: commit uses the old shadow value. The new value is stored and pending stays set for the next boundary.
  - Second write before commit: overwrites shadow; only one o_load is issued.
  - SET_EN in the same cycle as i_period_end: commit evaluation uses the pre-update enable mask.
- Status:
  - o_tx_data loaded and o_tx_load pulsed one cycle after the READ_STATUS header.
  - Status A = {pending[3:0], o_ch_en[3:0]}.
  - Status B = {6'b0, o_err}; the read clears o_err in the same cycle, and an error event in that cycle wins (stays set).
- o_err bits are sticky; they clear only on reset or a status-B read.
- Mid-operation reset: all state is cleared asynchronously, including in-flight frames and pending commits. o_load is never asserted during reset.

Test Plan:
- Reset, o_ch_en=0, send 0x40, 0x32 -> one cycle later o_duty[7:0]=50, o_load=0001 pulse, pending=0.
- Send 0x B C (0xBC: SET_EN=1111), then 0x41, 0x40 -> o_duty ch2 unchanged until i_period_end[1] pulses; next cycle ch2=64 and o_load=0010. The same write with period_end arriving in the header cycle produces no early commit.
- Send 0x42, 0xC8 (200) -> shadow ch3=100, o_err=01. Then send 0xC1 -> o_tx_data=0x01, o_tx_load pulse, and o_err clears to 00.
- Send 0x43, then idle for TIMEOUT cycles -> FSM in IDLE, o_err=10, ch4 unchanged. Repeat with i_ss_n raised after the header -> no error, no write.
- With ch1 enabled, send 0x40, 0x1E, then 0x40, 0x0A before i_period_end[0] -> a single commit of 10 with one o_load pulse. Then send 0xC0 -> o_tx_data=0x0F with pending=0.
- Assert i_rst=0 while pending[2]=1 and the FSM is in WAIT_DATA -> all outputs are 0 immediately. After release, i_period_end[2] produces no o_load.
